jtag_dr_bank: RTL and testbench



---
 rtl/jtag_pkg.sv | 37 +++
 rtl/jtag_bsr.sv | 42 ++++
 rtl/jtag_dr_bank.sv | 118 +++++++++++
 tb/tb_jtag_dr_bank.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtag_pkg
// Description : TAP state encoding, instruction opcodes and default IDCODE
//               shared by the TAP controller and the data register bank.
// Revision    : 1.0 - initial release
// ============================================================================
package jtag_pkg;

    typedef enum logic [3:0] {
        RESET      = 4'd0,
        RUN_IDLE   = 4'd1,
        SELECT_DR  = 4'd2,
        CAPTURE_DR = 4'd3,
        SHIFT_DR   = 4'd4,
        EXIT1_DR   = 4'd5,
        PAUSE_DR   = 4'd6,
        EXIT2_DR   = 4'd7,
        UPDATE_DR  = 4'd8,
        SELECT_IR  = 4'd9,
        CAPTURE_IR = 4'd10,
        SHIFT_IR   = 4'd11,
        EXIT1_IR   = 4'd12,
        PAUSE_IR   = 4'd13,
        EXIT2_IR   = 4'd14,
        UPDATE_IR  = 4'd15
    } tap_state_t;

    localparam logic [3:0]  c_op_extest         = 4'h0;
    localparam logic [3:0]  c_op_idcode         = 4'h1;
    localparam logic [3:0]  c_op_sample_preload = 4'h2;
    localparam logic [3:0]  c_op_bypass         = 4'hF;

    localparam logic [31:0] c_idcode_default    = 32'h149511C3;

endpackage
`default_nettype wire

// File: rtl/jtag_bsr.sv
`default_nettype none
// ============================================================================
// Module      : jtag_bsr
// Description : Boundary-scan register with shift stage and update stage.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_bsr #(
    parameter int BOUNDARY_LEN = 128
) (
    input  logic                    TCK,
    input  logic                    TRST_n,
    input  logic                    capture,
    input  logic                    shift,
    input  logic                    update,
    input  logic                    TDI,
    input  logic [BOUNDARY_LEN-1:0] pin_in,
    output logic                    sr0,
    output logic [BOUNDARY_LEN-1:0] update_q
);

    logic [BOUNDARY_LEN-1:0] r_shift_q;
    logic [BOUNDARY_LEN-1:0] r_update_q;

    always_ff @(posedge TCK) begin
        if (!TRST_n) begin
            r_shift_q  <= '0;
            r_update_q <= '0;
        end else begin
            if (capture)
                r_shift_q <= pin_in;
            else if (shift)
                r_shift_q <= {TDI, r_shift_q[BOUNDARY_LEN-1:1]};
            if (update)
                r_update_q <= r_shift_q;
        end
    end

    assign sr0      = r_shift_q[0];
    assign update_q = r_update_q;

endmodule
`default_nettype wire

// File: rtl/jtag_dr_bank.sv
`default_nettype none
// ============================================================================
// Module      : jtag_dr_bank
// Description : Instruction latch, BYPASS/IDCODE/BSR data registers and the
//               DR serial output, sitting downstream of the TAP controller.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_dr_bank
    import jtag_pkg::*;
#(
    parameter int          IR_LEN       = 4,
    parameter int          BOUNDARY_LEN = 128,
    parameter logic [31:0] IDCODE_VALUE = c_idcode_default
) (
    input  logic                    TCK,
    input  logic                    TRST_n,
    input  tap_state_t              tap_state,
    input  logic [IR_LEN-1:0]       ir_shift,
    input  logic                    TDI,
    input  logic [BOUNDARY_LEN-1:0] pin_in,
    input  logic [BOUNDARY_LEN-1:0] core_out,
    output logic [BOUNDARY_LEN-1:0] pin_out,
    output logic                    dr_tdo,
    output logic                    dr_tdo_en,
    output logic [IR_LEN-1:0]       active_ir,
    output logic                    extest_active
);

    logic [IR_LEN-1:0]       r_active_ir;
    logic                    r_bypass;
    logic [31:0]             r_idcode_sr;
    logic                    r_dr_tdo;
    logic                    r_dr_tdo_en;

    logic                    w_capture;
    logic                    w_shift;
    logic                    w_update;
    logic                    w_sel_bsr;
    logic                    w_sel_idcode;
    logic                    w_sel_bypass;
    logic                    w_extest;
    logic                    w_bsr_sr0;
    logic                    w_sel_bit;
    logic [BOUNDARY_LEN-1:0] w_bsr_update;

    assign w_capture = (tap_state == CAPTURE_DR);
    assign w_shift   = (tap_state == SHIFT_DR);
    assign w_update  = (tap_state == UPDATE_DR);

    // Unknown opcodes fall through to BYPASS.
    assign w_extest     = (r_active_ir == IR_LEN'(c_op_extest));
    assign w_sel_bsr    = w_extest || (r_active_ir == IR_LEN'(c_op_sample_preload));
    assign w_sel_idcode = (r_active_ir == IR_LEN'(c_op_idcode));
    assign w_sel_bypass = !w_sel_bsr && !w_sel_idcode;

    always_ff @(posedge TCK) begin
        if (!TRST_n || tap_state == RESET)
            r_active_ir <= IR_LEN'(c_op_idcode);
        else if (tap_state == UPDATE_IR)
            r_active_ir <= ir_shift;
    end

    always_ff @(posedge TCK) begin
        if (!TRST_n) begin
            r_bypass    <= 1'b0;
            r_idcode_sr <= IDCODE_VALUE;
        end else begin
            if (w_sel_bypass && w_capture)
                r_bypass <= 1'b0;
            else if (w_sel_bypass && w_shift)
                r_bypass <= TDI;
            if (w_sel_idcode && w_capture)
                r_idcode_sr <= IDCODE_VALUE;
            else if (w_sel_idcode && w_shift)
                r_idcode_sr <= {TDI, r_idcode_sr[31:1]};
        end
    end

    jtag_bsr #(
        .BOUNDARY_LEN (BOUNDARY_LEN)
    ) u_bsr (
        .TCK      (TCK),
        .TRST_n   (TRST_n),
        .capture  (w_sel_bsr && w_capture),
        .shift    (w_sel_bsr && w_shift),
        .update   (w_sel_bsr && w_update),
        .TDI      (TDI),
        .pin_in   (pin_in),
        .sr0      (w_bsr_sr0),
        .update_q (w_bsr_update)
    );

    always_comb begin
        w_sel_bit = r_bypass;
        if (w_sel_bsr)
            w_sel_bit = w_bsr_sr0;
        else if (w_sel_idcode)
            w_sel_bit = r_idcode_sr[0];
    end

    always_ff @(posedge TCK) begin
        if (!TRST_n || !w_shift) begin
            r_dr_tdo    <= 1'b0;
            r_dr_tdo_en <= 1'b0;
        end else begin
            r_dr_tdo    <= w_sel_bit;
            r_dr_tdo_en <= 1'b1;
        end
    end

    assign pin_out       = w_extest ? w_bsr_update : core_out;
    assign dr_tdo        = r_dr_tdo;
    assign dr_tdo_en     = r_dr_tdo_en;
    assign active_ir     = r_active_ir;
    assign extest_active = w_extest;

endmodule
`default_nettype wire

// File: tb/tb_jtag_dr_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_dr_bank
// Description : Directed self-checking bench for jtag_dr_bank (8 boundary cells).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_dr_bank;
    import jtag_pkg::*;

    localparam int c_blen = 8;

    logic              TCK = 1'b0;
    logic              TRST_n;
    tap_state_t        tap_state;
    logic [3:0]        ir_shift;
    logic              TDI;
    logic [c_blen-1:0] pin_in;
    logic [c_blen-1:0] core_out;
    logic [c_blen-1:0] pin_out;
    logic              dr_tdo;
    logic              dr_tdo_en;
    logic [3:0]        active_ir;
    logic              extest_active;

    int errors = 0;
    int checks = 0;

    jtag_dr_bank #(
        .IR_LEN       (4),
        .BOUNDARY_LEN (c_blen),
        .IDCODE_VALUE (32'h149511C3)
    ) dut (
        .TCK           (TCK),
        .TRST_n        (TRST_n),
        .tap_state     (tap_state),
        .ir_shift      (ir_shift),
        .TDI           (TDI),
        .pin_in        (pin_in),
        .core_out      (core_out),
        .pin_out       (pin_out),
        .dr_tdo        (dr_tdo),
        .dr_tdo_en     (dr_tdo_en),
        .active_ir     (active_ir),
        .extest_active (extest_active)
    );

    always #5 TCK = ~TCK;

    // One TCK edge with the given state/TDI; outputs are stable on return.
    task automatic step(input tap_state_t s, input logic t);
        tap_state = s;
        TDI       = t;
        @(posedge TCK);
        #1;
    endtask

    task automatic load_ir(input logic [3:0] op);
        ir_shift = op;
        step(SELECT_DR, 1'b0);
        step(SELECT_IR, 1'b0);
        step(CAPTURE_IR, 1'b0);
        step(SHIFT_IR, 1'b0);
        step(EXIT1_IR, 1'b0);
        step(UPDATE_IR, 1'b0);
    endtask

    task automatic test_reset;
        TRST_n = 1'b0;
        step(RESET, 1'b0);
        step(RUN_IDLE, 1'b0);
        checks++; if (active_ir !== 4'h1) begin errors++; $display("FAIL reset_ir: got %h want %h", active_ir, 4'h1); end
        checks++; if (dr_tdo !== 1'b0) begin errors++; $display("FAIL reset_tdo: got %b want 0", dr_tdo); end
        checks++; if (dr_tdo_en !== 1'b0) begin errors++; $display("FAIL reset_tdo_en: got %b want 0", dr_tdo_en); end
        checks++; if (extest_active !== 1'b0) begin errors++; $display("FAIL reset_extest: got %b want 0", extest_active); end
        checks++; if (pin_out !== core_out) begin errors++; $display("FAIL reset_pin_out: got %h want %h", pin_out, core_out); end
        TRST_n = 1'b1;
        step(RUN_IDLE, 1'b0);
    endtask

    task automatic test_idcode;
        logic [31:0] got;
        got = '0;
        step(SELECT_DR, 1'b0);
        step(CAPTURE_DR, 1'b0);
        for (int i = 0; i < 32; i++) begin
            step(SHIFT_DR, 1'b0);
            got[i] = dr_tdo;
            if (i == 0) begin
                checks++; if (dr_tdo_en !== 1'b1) begin errors++; $display("FAIL idcode_en: got %b want 1", dr_tdo_en); end
            end
        end
        checks++; if (got !== 32'h149511C3) begin errors++; $display("FAIL idcode_word: got %h want %h", got, 32'h149511C3); end
        checks++; if (active_ir !== 4'h1) begin errors++; $display("FAIL idcode_ir: got %h want 1", active_ir); end
        step(EXIT1_DR, 1'b0);
        checks++; if (dr_tdo_en !== 1'b0 || dr_tdo !== 1'b0) begin errors++; $display("FAIL idcode_exit: got en=%b tdo=%b want 0/0", dr_tdo_en, dr_tdo); end
        step(UPDATE_DR, 1'b0);
        step(RUN_IDLE, 1'b0);
    endtask

    task automatic test_bypass(input logic [3:0] op);
        logic [3:0] tdi_seq;
        logic [3:0] got;
        tdi_seq = 4'b1101;   // bit i is the TDI of the i-th shift: 1,0,1,1
        got     = '0;
        load_ir(op);
        checks++; if (active_ir !== op) begin errors++; $display("FAIL bypass_ir: got %h want %h", active_ir, op); end
        checks++; if (extest_active !== 1'b0 || pin_out !== core_out) begin errors++; $display("FAIL bypass_pins: got ext=%b pin=%h want 0/%h", extest_active, pin_out, core_out); end
        step(SELECT_DR, 1'b0);
        step(CAPTURE_DR, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(SHIFT_DR, tdi_seq[i]);
            got[i] = dr_tdo;
        end
        checks++; if (got !== 4'b1010) begin errors++; $display("FAIL bypass_shift_%h: got %b want %b", op, got, 4'b1010); end
        step(EXIT1_DR, 1'b0);
        step(UPDATE_DR, 1'b0);
        step(RUN_IDLE, 1'b0);
    endtask

    task automatic test_sample_preload;
        logic [7:0] tdi_seq;
        logic [7:0] got;
        tdi_seq = 8'h3C;
        got     = '0;
        pin_in  = 8'hA5;
        load_ir(4'h2);
        checks++; if (active_ir !== 4'h2) begin errors++; $display("FAIL sp_ir: got %h want 2", active_ir); end
        step(SELECT_DR, 1'b0);
        step(CAPTURE_DR, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(SHIFT_DR, tdi_seq[i]);
            got[i] = dr_tdo;
        end
        checks++; if (got !== 8'hA5) begin errors++; $display("FAIL sp_shift: got %h want %h", got, 8'hA5); end
        step(EXIT1_DR, 1'b0);
        step(UPDATE_DR, 1'b0);
        step(RUN_IDLE, 1'b0);
        checks++; if (pin_out !== core_out) begin errors++; $display("FAIL sp_pin_out: got %h want %h", pin_out, core_out); end
        checks++; if (extest_active !== 1'b0) begin errors++; $display("FAIL sp_extest: got %b want 0", extest_active); end
    endtask

    task automatic test_extest_entry;
        load_ir(4'h0);
        checks++; if (pin_out !== 8'h3C) begin errors++; $display("FAIL ext_pin_out: got %h want %h", pin_out, 8'h3C); end
        checks++; if (extest_active !== 1'b1) begin errors++; $display("FAIL ext_active: got %b want 1", extest_active); end
        checks++; if (active_ir !== 4'h0) begin errors++; $display("FAIL ext_ir: got %h want 0", active_ir); end
        step(RUN_IDLE, 1'b0);
    endtask

    task automatic test_pause_resume;
        logic [7:0] tdi_seq;
        logic [7:0] got;
        tdi_seq = 8'h3C;
        got     = '0;
        pin_in  = 8'h96;
        step(SELECT_DR, 1'b0);
        step(CAPTURE_DR, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(SHIFT_DR, tdi_seq[i]);
            got[i] = dr_tdo;
        end
        step(EXIT1_DR, 1'b1);
        for (int i = 0; i < 3; i++) step(PAUSE_DR, 1'b1);
        checks++; if (dr_tdo_en !== 1'b0) begin errors++; $display("FAIL pause_en: got %b want 0", dr_tdo_en); end
        step(EXIT2_DR, 1'b1);
        for (int i = 4; i < 8; i++) begin
            step(SHIFT_DR, tdi_seq[i]);
            got[i] = dr_tdo;
        end
        checks++; if (got !== 8'h96) begin errors++; $display("FAIL pause_shift: got %h want %h", got, 8'h96); end
        step(EXIT1_DR, 1'b0);
        step(UPDATE_DR, 1'b0);
        checks++; if (pin_out !== 8'h3C) begin errors++; $display("FAIL pause_update: got %h want %h", pin_out, 8'h3C); end
        step(RUN_IDLE, 1'b0);
    endtask

    task automatic test_reset_midway;
        load_ir(4'h0);
        step(RUN_IDLE, 1'b0);
        checks++; if (pin_out !== 8'h3C) begin errors++; $display("FAIL rst_pre_pin: got %h want %h", pin_out, 8'h3C); end
        step(SELECT_DR, 1'b0);
        step(CAPTURE_DR, 1'b0);
        step(SHIFT_DR, 1'b1);
        TRST_n = 1'b0;
        step(SHIFT_DR, 1'b1);
        checks++; if (active_ir !== 4'h1) begin errors++; $display("FAIL rst_ir: got %h want 1", active_ir); end
        checks++; if (pin_out !== core_out) begin errors++; $display("FAIL rst_pin_out: got %h want %h", pin_out, core_out); end
        checks++; if (dr_tdo_en !== 1'b0 || extest_active !== 1'b0) begin errors++; $display("FAIL rst_outs: got en=%b ext=%b want 0/0", dr_tdo_en, extest_active); end
        TRST_n = 1'b1;
        step(RUN_IDLE, 1'b0);
        load_ir(4'h0);
        checks++; if (pin_out !== 8'h00) begin errors++; $display("FAIL rst_update_cleared: got %h want 00", pin_out); end
        step(RESET, 1'b0);
        checks++; if (active_ir !== 4'h1 || extest_active !== 1'b0) begin errors++; $display("FAIL tlr_ir: got %h ext=%b want 1/0", active_ir, extest_active); end
        step(RUN_IDLE, 1'b0);
    endtask

    initial begin
        TRST_n    = 1'b0;
        tap_state = RESET;
        ir_shift  = 4'h0;
        TDI       = 1'b0;
        pin_in    = 8'h00;
        core_out  = 8'hC3;
        test_reset();
        test_idcode();
        test_bypass(4'hF);
        test_sample_preload();
        test_extest_entry();
        test_pause_resume();
        test_bypass(4'h7);
        test_reset_midway();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
